// File: rtl/vid_fetch.sv
// vid_fetch: SDRAM burst prefetcher feeding a first-word-fall-through video FIFO.
// Define VID_FETCH_UNDERRUN_EN to build the sticky underrun detector; otherwise underrun is tied low.
module vid_fetch #(
  parameter logic [21:0] BASE_ADDR   = 22'h000000,
  parameter int          FRAME_WORDS = 153600,
  parameter int          BURST       = 8,
  parameter int          DEPTH       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        req,
  input  logic        vsync,
  output logic [31:0] viddata,
  output logic        rd_req,
  output logic [21:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        underrun
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(BURST + 1);
  localparam logic [21:0]   FW   = 22'(FRAME_WORDS);
  localparam logic [21:0]   BL   = 22'(BURST);
  localparam logic [LW-1:0] ROOM = LW'(DEPTH - BURST);
  localparam logic [BW-1:0] LAST = BW'(BURST - 1);
  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [21:0] words_issued_q, words_issued_d;
  logic [BW-1:0] beat_q, beat_d;
  logic vsync_q, frame_start, empty, pop, push, last_beat, flush, ack;
  assign frame_start = vsync & ~vsync_q;
  assign empty       = level_q == '0;
  assign pop         = req & ce & ~empty;
  assign last_beat   = rd_valid && beat_q == LAST;
  assign ack         = state_q == REQ && rd_ack;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // A frame start on the final beat of a burst has nothing left to drain, so it flushes at once.
  always_comb begin
    state_d = state_q;
    flush = 1'b0;
    case (state_q)
      IDLE: begin
        flush = frame_start;
        if (!frame_start && level_q <= ROOM && words_issued_q < FW) state_d = REQ;
      end
      REQ: begin
        flush = frame_start & ~rd_ack;
        if (rd_ack) state_d = frame_start ? DRAIN : DATA;
        else if (frame_start) state_d = IDLE;
      end
      DATA: begin
        flush = frame_start & last_beat;
        if (last_beat) state_d = IDLE;
        else if (frame_start) state_d = DRAIN;
      end
      default: begin
        flush = last_beat;
        if (last_beat) state_d = IDLE;
      end
    endcase
  end
  // Beats whose frame position lies beyond FRAME_WORDS belong to the padded final burst and are dropped.
  always_comb begin
    rd_req  = state_q == REQ;
    rd_addr = BASE_ADDR + words_issued_q;
    push    = state_q == DATA && rd_valid && (words_issued_q - BL + 22'(beat_q)) < FW;
    viddata = empty ? 32'h0 : mem[rptr_q];
  end
  always_comb begin
    words_issued_d = flush ? '0 : words_issued_q + (ack ? BL : 22'h0);
    beat_d         = ack ? '0 : beat_q + BW'(rd_valid && (state_q == DATA || state_q == DRAIN));
    rptr_d         = flush ? '0 : rptr_q + PW'(pop);
    wptr_d         = flush ? '0 : wptr_q + PW'(push);
    level_d        = flush ? '0 : level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rptr_q         <= '0;
      wptr_q         <= '0;
      level_q        <= '0;
      words_issued_q <= '0;
      beat_q         <= '0;
      vsync_q        <= 1'b0;
    end else begin
      rptr_q         <= rptr_d;
      wptr_q         <= wptr_d;
      level_q        <= level_d;
      words_issued_q <= words_issued_d;
      beat_q         <= beat_d;
      vsync_q        <= vsync;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr_q] <= rd_data;
`ifdef VID_FETCH_UNDERRUN_EN
  logic underrun_q, underrun_d;
  assign underrun_d = frame_start ? 1'b0 : underrun_q | (req & ce & empty);
  always_ff @(posedge clk or posedge rst)
    if (rst) underrun_q <= 1'b0;
    else underrun_q <= underrun_d;
  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif
endmodule
